multi_clock_divider: RTL
========================

// Module: multi_clock_divider
// PURPOSE
//  N_CH independent programmable clock dividers driven from one system clock.
//  Each channel produces a registered divided clock (clk_out) and a 1-cycle enable pulse (tick).
//  Divisors are written at run time through a valid/ready port and applied glitch-free at period boundaries.
//  A shared sync input phase-aligns all channels. Sits between the system clock and slow peripherals (LED/PWM/UART timing).
// PARAMETERS
//  N_CH   4   number of divider channels (1..16)
//  CNT_W  20  divisor/counter width; max divisor 2**CNT_W-1 (covers 1_000_000)
//  CH_W   $clog2(N_CH) (min 1)  localparam, channel index width
// PORTS
//  clk       in   1      system clock, all logic on rising edge
//  rst       in   1      asynchronous, active-low reset
//  wr_valid  in   1      divisor write request
//  wr_ready  out  1      write can be accepted this cycle
//  wr_ch     in   CH_W   target channel of write
//  wr_div    in   CNT_W  new divisor D (clk cycles per output period)
//  sync      in   1      restart all running channels at count 0
//  clk_out   out  N_CH   divided clocks, one bit per channel
//  tick      out  N_CH   one-clk pulse per divided period, one bit per channel
//  pending   out  N_CH   channel has a written divisor not yet applied
// BEHAVIOUR
//  Reset (rst=0, async): every cnt=0, active D=0, shadow=0, pending=0, clk_out=0, tick=0; wr_ready=1 after release.
//  Per channel: active D, shadow D, pending flag, counter cnt in [0, D-1].
//  Write accept: wr_valid & wr_ready at an edge -> shadow[wr_ch]<=wr_div, pending[wr_ch]<=1.
//  wr_ready = ~pending[wr_ch] (combinational on wr_ch). A write to a channel whose update is still pending stalls.
//  wr_ch >= N_CH: accepted (wr_ready=1), data dropped, no state changes.
//  Apply: if pending and (active D==0 or cnt==D-1 or sync) at an edge -> active<=shadow, cnt<=0, pending<=0.
//  Idle channel latency: accepted at edge k, loaded at edge k+1, first clk_out high at edge k+1.
//  Counting: D>=1 -> cnt wraps D-1 -> 0, else cnt+1. D==0 -> channel stopped: cnt=0, clk_out=0, tick=0.
//  Outputs are registered from next-state values.
//  clk_out <= (cnt_next < H), where H = D>>1 for D>=2. D=4 gives 1,1,0,0. D=5 gives 1,1,0,0,0.
//  D==1: clk_out=0, tick held 1 (every cycle).
//  tick <= (D_next!=0) & (cnt_next == D_next-1). The pulse is in the last cycle of each period.
//  sync=1 at an edge: every channel with active D!=0 -> cnt<=0 (clk_out<=1 if H>0). Pending divisors are applied at the same edge.
//  sync held high: counters stay at 0.
//  Simultaneous sync and accepted write to the same channel: sync restarts with the old active D.
//  The new D stays pending until the next boundary.
//  Writing D=0 to a running channel: stops cleanly at end of the current period, with no runt pulse.
//  Shortening/lengthening D mid-period: never truncates the current period.
//  No arithmetic overflow: cnt is CNT_W bits and is compared with D-1 only when D!=0.
//  Reset asserted mid-operation: all outputs go to 0 immediately (async). Any pending write is lost.
// STRUCTURE
//  Package clkdiv_pkg: CNT_W default constant, typedef logic [CNT_W-1:0] div_t,
//  struct chan_state_t {div_t active, shadow, cnt; logic pending}.
//  Sub-module clkdiv_channel: one counter plus apply logic.
//  Ports: clk, rst, load_en, load_div, sync, clk_out, tick, pending.
//  Top level: decodes wr_ch, generates wr_ready, and instantiates N_CH channels with a generate loop.
// TESTING
//  1 Reset: hold rst=0 for 3 clks with wr_valid=1 -> all outputs 0, no write taken; after release wr_ready=1.
//  2 Write D=4 to ch0 while idle -> pending[0] high 1 clk; clk_out[0] = 1,1,0,0 repeating; tick[0] every 4th clk.
//  3 Ch0 running D=4, write D=6 mid-period -> current 4-cycle period completes, then 6-cycle period 1,1,1,0,0,0.
//    A 2nd write before apply sees wr_ready=0.
//  4 Ch0 D=4, ch1 D=6, both running; pulse sync 1 clk -> both cnt=0 at the same edge.
//    Rising clk_out edges coincide, then again every 12 clks.
//  5 Write D=1 -> tick stays 1, clk_out 0. Write D=0 -> outputs 0 after period end. D=5 -> high 2, low 3.
//  6 Async reset asserted mid-period with a pending write -> outputs 0 at once; after release channel idle, pending=0.

Source files
------------

// File: rtl/clkdiv_pkg.sv
// Shared types for the multi-channel clock divider: divisor width and per-channel state.
package clkdiv_pkg;

    localparam int CNT_W_DEF = 20;

    typedef logic [CNT_W_DEF-1:0] div_t;

    typedef struct packed {
        div_t active;
        div_t shadow;
        div_t cnt;
        logic pending;
    } chan_state_t;

endpackage

// File: rtl/clkdiv_channel.sv
// One divider channel: period counter, shadow divisor and boundary-aligned apply.
// Outputs are registered from the next-state counter so they line up with cnt.
module clkdiv_channel
    import clkdiv_pkg::*;
(
    input  logic clk,
    input  logic rst,
    input  logic load_en,
    input  div_t load_div,
    input  logic sync,
    output logic clk_out,
    output logic tick,
    output logic pending
);

    chan_state_t r_st;
    chan_state_t w_st_nxt;
    logic        r_clk_out;
    logic        r_tick;
    logic        w_last;
    logic        w_apply;
    logic        w_clk_nxt;
    logic        w_tick_nxt;
    div_t        w_half;

    always_comb begin
        w_st_nxt = r_st;
        w_last   = (r_st.active != '0) && (r_st.cnt == r_st.active - div_t'(1));
        w_apply  = r_st.pending && ((r_st.active == '0) || w_last || sync);
        if (w_apply) begin
            w_st_nxt.active  = r_st.shadow;
            w_st_nxt.cnt     = '0;
            w_st_nxt.pending = 1'b0;
        end else begin
            // load_en only arrives when nothing is pending, so it never races an apply
            if (load_en) begin
                w_st_nxt.shadow  = load_div;
                w_st_nxt.pending = 1'b1;
            end
            if ((r_st.active == '0) || sync || w_last) begin
                w_st_nxt.cnt = '0;
            end else begin
                w_st_nxt.cnt = r_st.cnt + div_t'(1);
            end
        end
    end

    always_comb begin
        w_half     = w_st_nxt.active >> 1;
        w_clk_nxt  = (w_half != '0) && (w_st_nxt.cnt < w_half);
        w_tick_nxt = (w_st_nxt.active != '0) &&
                     (w_st_nxt.cnt == w_st_nxt.active - div_t'(1));
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_st      <= '0;
            r_clk_out <= 1'b0;
            r_tick    <= 1'b0;
        end else begin
            r_st      <= w_st_nxt;
            r_clk_out <= w_clk_nxt;
            r_tick    <= w_tick_nxt;
        end
    end

    assign clk_out = r_clk_out;
    assign tick    = r_tick;
    assign pending = r_st.pending;

endmodule

// File: rtl/multi_clock_divider.sv
// N_CH independent programmable clock dividers sharing one write port and one sync input.
// A write to a channel with an unapplied divisor stalls; out-of-range channels are accepted and dropped.
module multi_clock_divider
    import clkdiv_pkg::*;
#(
    parameter  int N_CH  = 4,
    parameter  int CNT_W = CNT_W_DEF,
    localparam int CH_W  = (N_CH > 1) ? $clog2(N_CH) : 1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             wr_valid,
    output logic             wr_ready,
    input  logic [CH_W-1:0]  wr_ch,
    input  logic [CNT_W-1:0] wr_div,
    input  logic             sync,
    output logic [N_CH-1:0]  clk_out,
    output logic [N_CH-1:0]  tick,
    output logic [N_CH-1:0]  pending
);

    // Channel state is built on the package divisor type, so the widths must agree.
    if (CNT_W != CNT_W_DEF) begin : g_bad_width
        $error("multi_clock_divider: CNT_W must equal clkdiv_pkg::CNT_W_DEF");
    end

    logic [N_CH-1:0] w_sel;
    logic [N_CH-1:0] w_load;

    always_comb begin
        w_sel = '0;
        for (int i = 0; i < N_CH; i++) begin
            w_sel[i] = (wr_ch == CH_W'(i));
        end
    end

    assign wr_ready = ~|(w_sel & pending);
    assign w_load   = w_sel & {N_CH{wr_valid & wr_ready}};

    for (genvar g = 0; g < N_CH; g++) begin : g_ch
        clkdiv_channel u_ch (
            .clk      (clk),
            .rst      (rst),
            .load_en  (w_load[g]),
            .load_div (wr_div),
            .sync     (sync),
            .clk_out  (clk_out[g]),
            .tick     (tick[g]),
            .pending  (pending[g])
        );
    end

endmodule
